// File: rtl/led_pwm_ctrl.sv
// LED controller: memory-mapped DATA/MODE/DUTY/BLINK registers driving PWM-dimmed, optionally blinking LEDs.
// Optional blink logic is built only when the LED_PWM_BLINK_EN macro is defined.
module led_pwm_ctrl #(
   parameter int LEDS_WIDTH = 8,
   parameter int PWM_BITS   = 8,
   parameter int PRESCALE   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  read_request_i,
   input  logic                  write_request_i,
   input  logic [31:0]           address_i,
   input  logic [31:0]           write_data_i,
   output logic [31:0]           read_data_o,
   output logic                  response_o,
   output logic [LEDS_WIDTH-1:0] leds
);

   localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      REG_DATA  = 2'd0,
      REG_MODE  = 2'd1,
      REG_DUTY  = 2'd2,
      REG_BLINK = 2'd3
   } reg_sel_e;

   reg_sel_e              w_sel;
   logic                  w_wr_data;
   logic                  w_wr_mode;
   logic                  w_wr_duty;
   logic                  w_wr_blink;
   logic                  w_tick;
   logic                  w_pwm_on;
   logic                  w_blink_phase;
   logic [15:0]           w_blink_rd;
   logic [LEDS_WIDTH-1:0] w_gate;
   logic                  w_unused_bits;

   logic [LEDS_WIDTH-1:0] r_data;
   logic [LEDS_WIDTH-1:0] r_mode;
   logic [PWM_BITS-1:0]   r_duty;
   logic [PRESC_W-1:0]    r_presc;
   logic [PWM_BITS-1:0]   r_pwm_cnt;
   logic [LEDS_WIDTH-1:0] r_leds;

   assign w_sel      = reg_sel_e'(address_i[3:2]);
   assign w_wr_data  = write_request_i && (w_sel == REG_DATA);
   assign w_wr_mode  = write_request_i && (w_sel == REG_MODE);
   assign w_wr_duty  = write_request_i && (w_sel == REG_DUTY);
   assign w_wr_blink = write_request_i && (w_sel == REG_BLINK);

   // Only address bits [3:2] and the low register bits of the write data are decoded.
   assign w_unused_bits = ^{address_i, write_data_i};

   assign response_o = read_request_i | write_request_i;

   // NOTE: synchronous reset sits inside the clocked branch, so it wins over any same-edge write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data <= '0;
         r_mode <= '0;
         r_duty <= '0;
      end else begin
         if (w_wr_data) r_data <= write_data_i[LEDS_WIDTH-1:0];
         if (w_wr_mode) r_mode <= write_data_i[LEDS_WIDTH-1:0];
         if (w_wr_duty) r_duty <= write_data_i[PWM_BITS-1:0];
      end
   end

   assign w_tick = (r_presc == PRESC_LAST);

   // A DUTY write never disturbs the counters, so the new level applies mid-period.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc   <= '0;
         r_pwm_cnt <= '0;
      end else if (w_tick) begin
         r_presc   <= '0;
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end else begin
         r_presc   <= r_presc + 1'b1;
      end
   end

   assign w_pwm_on = (r_pwm_cnt < r_duty);

`ifdef LED_PWM_BLINK_EN
   logic        w_pwm_wrap;
   logic [15:0] r_blink;
   logic [15:0] r_blink_cnt;
   logic        r_blink_phase;

   assign w_pwm_wrap = w_tick && (&r_pwm_cnt);

   // Counts PWM periods; phase flips after BLINK of them, BLINK=0 parks the LEDs in the on phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_blink       <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (w_wr_blink) begin
         r_blink       <= write_data_i[15:0];
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (r_blink == 16'd0) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (w_pwm_wrap) begin
         if (r_blink_cnt == r_blink - 16'd1) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt   <= r_blink_cnt + 16'd1;
         end
      end
   end

   assign w_blink_phase = r_blink_phase;
   assign w_blink_rd    = r_blink;
`else
   logic w_unused_blink_wr;

   assign w_unused_blink_wr = w_wr_blink;
   assign w_blink_phase     = 1'b1;
   assign w_blink_rd        = 16'h0;
`endif

   // NOTE: default assignment first keeps this combinational read mux latch-free.
   always_comb begin
      read_data_o = 32'h0;
      if (read_request_i) begin
         case (w_sel)
            REG_DATA:  read_data_o[LEDS_WIDTH-1:0] = r_data;
            REG_MODE:  read_data_o[LEDS_WIDTH-1:0] = r_mode;
            REG_DUTY:  read_data_o[PWM_BITS-1:0]   = r_duty;
            REG_BLINK: read_data_o[15:0]           = w_blink_rd;
            default:   read_data_o                 = 32'h0;
         endcase
      end
   end

   assign w_gate = {LEDS_WIDTH{w_pwm_on & w_blink_phase}};

   // Static LEDs follow DATA; modulated LEDs are additionally gated by PWM and blink phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_leds <= '0;
      end else begin
         r_leds <= r_data & (~r_mode | w_gate);
      end
   end

   assign leds = r_leds;

endmodule
